// File: rtl/tlul_host_arb_pkg.sv
// rtl/tlul_host_arb_pkg.sv - shared types, size codes and index-width helper for tlul_host_arb
package tlul_host_arb_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Wide enough to name any of up to 8 requesters.
  typedef logic [2:0] arb_sel_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlul_host_arb_fifo.sv
// rtl/tlul_host_arb_fifo.sv - in-order source tracking FIFO for tlul_host_arb
module tlul_host_arb_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push,
  input  logic [W-1:0]                   wdata,
  input  logic                           pop,
  output logic [W-1:0]                   rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tlul_host_arb.sv
// rtl/tlul_host_arb.sv - N-to-1 TL-UL host port arbiter with in-order response routing
// Define TLUL_HOST_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module tlul_host_arb
  import tlul_host_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N-1:0]      req_i,
  output logic [N-1:0]      gnt_o,
  input  logic [N*AW-1:0]   addr_i,
  input  logic [N-1:0]      we_i,
  input  logic [N*DW-1:0]   wdata_i,
  input  logic [N*DW/8-1:0] be_i,
  input  logic [N*2-1:0]    size_i,
  output logic [N-1:0]      valid_o,
  output logic [DW-1:0]     rdata_o,
  output logic              req_o,
  output logic [AW-1:0]     addr_o,
  output logic              we_o,
  output logic [DW-1:0]     wdata_o,
  output logic [DW/8-1:0]   be_o,
  output logic [1:0]        size_o,
  input  logic              gnt_i,
  input  logic              valid_i,
  input  logic [DW-1:0]     rdata_i,
  output logic              unexp_rsp_o
);

  localparam int IdxW = idx_w(N);
  localparam int CntW = $clog2(MAX_OUT + 1);

  arb_sel_t        win;
  arb_sel_t        sel;
  arb_sel_t        lock_idx;
  logic            locked;
  logic            gnt;
  logic            full;
  logic            empty;
  logic [IdxW-1:0] head;
  logic [CntW-1:0] out_cnt;
  logic            unused_cnt;

`ifdef TLUL_HOST_ARB_RR_EN
  arb_sel_t rr_ptr;

  // Scan downward so the candidate closest after rr_ptr is written last and wins.
  always_comb begin
    int j;
    win = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N;
      if (req_i[j[IdxW-1:0]]) win = arb_sel_t'(j);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (gnt) begin
      rr_ptr <= arb_sel_t'((int'(sel) + 1) % N);
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) win = arb_sel_t'(i);
    end
  end
`endif

  assign sel     = locked ? lock_idx : win;
  assign req_o   = (|req_i) & ~full;
  assign gnt     = req_o & gnt_i;
  assign gnt_o   = gnt ? (N'(1) << sel) : '0;

  assign addr_o  = addr_i[int'(sel)*AW +: AW];
  assign we_o    = we_i[sel];
  assign wdata_o = wdata_i[int'(sel)*DW +: DW];
  assign be_o    = be_i[int'(sel)*(DW/8) +: DW/8];
  assign size_o  = size_i[int'(sel)*2 +: 2];

  // Hold the chosen requester until the adapter accepts it; full leaves the lock untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (req_o && !gnt_i) begin
      locked   <= 1'b1;
      lock_idx <= sel;
    end else if (gnt) begin
      locked   <= 1'b0;
    end
  end

  tlul_host_arb_fifo #(
    .W     (IdxW),
    .DEPTH (MAX_OUT)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (gnt),
    .wdata (sel[IdxW-1:0]),
    .pop   (valid_i),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (out_cnt)
  );

  assign unused_cnt  = ^out_cnt;

  assign valid_o     = (valid_i && !empty) ? (N'(1) << head) : '0;
  assign unexp_rsp_o = valid_i & empty;
  assign rdata_o     = rdata_i;

endmodule
